// File: rtl/crypto_seq_pkg.sv
// rtl/crypto_seq_pkg.sv - shared encodings, state enum and widths for the crypto job sequencer
package crypto_seq_pkg;

  localparam int KEY_W  = 168;
  localparam int DATA_W = 64;
  localparam int RSEL_W = 6;
  localparam int ALG_W  = 2;
  localparam int CNT_W  = 8;

  typedef enum logic [ALG_W-1:0] {
    ALG_DES3    = 2'd0,
    ALG_PRESENT = 2'd1,
    ALG_HIGHT   = 2'd2,
    ALG_ILLEGAL = 2'd3
  } alg_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD_KEY,
    ST_LOAD_DATA,
    ST_RUN,
    ST_DRAIN,
    ST_CAPTURE,
    ST_RESP
  } state_t;

endpackage

// File: rtl/crypto_job_sequencer_if.sv
// rtl/crypto_job_sequencer_if.sv - host job request / response channel bundle
// master: host side (offers jobs, accepts results)
// slave : sequencer side (accepts jobs, returns results)
interface crypto_job_sequencer_if;
  import crypto_seq_pkg::*;

  logic                req_valid;
  logic                req_ready;
  logic [ALG_W-1:0]    req_alg;
  logic                req_decrypt;
  logic [KEY_W-1:0]    req_key;
  logic [DATA_W-1:0]   req_data;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [DATA_W-1:0]   rsp_data;
  logic [ALG_W-1:0]    rsp_alg;
  logic                rsp_err;

  modport master (
    output req_valid, req_alg, req_decrypt, req_key, req_data, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_alg, rsp_err
  );

  modport slave (
    input  req_valid, req_alg, req_decrypt, req_key, req_data, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_alg, rsp_err
  );

endinterface

// File: rtl/crypto_seq_counter.sv
// rtl/crypto_seq_counter.sv - loadable up-counter with terminal flag
// Ports: clk, reset (async, active-high), load (restart at 0 with new limit),
//        en (count up), limit, count, done (count == latched limit)
module crypto_seq_counter
  import crypto_seq_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] limit,
  output logic [W-1:0] count,
  output logic         done
);

  logic [W-1:0] limit_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count   <= '0;
      limit_q <= '0;
    end else if (load) begin
      count   <= '0;
      limit_q <= limit;
    end else if (en && !done) begin
      count <= count + 1'b1;
    end
  end

  assign done = (count == limit_q);

endmodule

// File: rtl/crypto_job_sequencer.sv
// rtl/crypto_job_sequencer.sv - host-side job sequencer for the DES3/PRESENT/HIGHT engine
// Ports: clk, reset (async, active-high); bus (job request / response, slave side);
//        eng_* outputs drive the engine's data, key, select and load pins;
//        eng_output / eng_ready_o come back from the engine.
module crypto_job_sequencer
  import crypto_seq_pkg::*;
#(
  parameter int DES_ROUNDS     = 16,
  parameter int PRESENT_CYCLES = 32,
  parameter int PIPE_LAT       = 2,
  parameter int HIGHT_TIMEOUT  = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  crypto_job_sequencer_if.slave bus,
  output logic [DATA_W-1:0]     eng_input,
  output logic [KEY_W-1:0]      eng_key,
  output logic [ALG_W-1:0]      eng_sel,
  output logic [RSEL_W-1:0]     eng_roundSel,
  output logic                  eng_decrypt,
  output logic                  eng_op,
  output logic                  eng_key_load,
  output logic                  eng_data_load,
  output logic                  eng_post_rdy,
  input  logic [DATA_W-1:0]     eng_output,
  input  logic                  eng_ready_o
);

  localparam logic [CNT_W-1:0] DES_LIM   = CNT_W'(DES_ROUNDS - 1);
  localparam logic [CNT_W-1:0] PRE_LIM   = CNT_W'(PRESENT_CYCLES - 1);
  localparam logic [CNT_W-1:0] HIGHT_LIM = CNT_W'(HIGHT_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] DRAIN_LIM = CNT_W'(PIPE_LAT - 1);

  state_t             state;
  logic [ALG_W-1:0]   alg_q;
  logic               decrypt_q;
  logic               cnt_load;
  logic               cnt_en;
  logic [CNT_W-1:0]   cnt_limit;
  logic [CNT_W-1:0]   cnt;
  logic               cnt_done;

  // One counter serves RUN and DRAIN: it is reloaded on entry to RUN and
  // again on the RUN->DRAIN transition.
  always_comb begin
    cnt_load  = 1'b0;
    cnt_en    = 1'b0;
    cnt_limit = '0;
    case (state)
      ST_LOAD_DATA: begin
        cnt_load = 1'b1;
        if (alg_q == ALG_DES3)         cnt_limit = DES_LIM;
        else if (alg_q == ALG_PRESENT) cnt_limit = PRE_LIM;
        else                           cnt_limit = HIGHT_LIM;
      end
      ST_RUN: begin
        if (cnt_done) begin
          cnt_load  = 1'b1;
          cnt_limit = DRAIN_LIM;
        end else begin
          cnt_en = 1'b1;
        end
      end
      ST_DRAIN: cnt_en = 1'b1;
      default: ;
    endcase
  end

  crypto_seq_counter #(.W(CNT_W)) u_counter (
    .clk   (clk),
    .reset (reset),
    .load  (cnt_load),
    .en    (cnt_en),
    .limit (cnt_limit),
    .count (cnt),
    .done  (cnt_done)
  );

  // Job fields stay latched until the next accept so the engine sees stable
  // select/direction for the whole job (DES3 uses decrypt unregistered).
  assign eng_sel      = alg_q;
  assign bus.rsp_alg  = alg_q;
  assign eng_decrypt  = decrypt_q;
  assign eng_op       = decrypt_q;
  assign eng_roundSel = (state == ST_RUN && alg_q == ALG_DES3) ? RSEL_W'(cnt) : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= ST_IDLE;
      bus.req_ready <= 1'b1;
      bus.rsp_valid <= 1'b0;
      bus.rsp_err   <= 1'b0;
      bus.rsp_data  <= '0;
      alg_q         <= '0;
      decrypt_q     <= 1'b0;
      eng_input     <= '0;
      eng_key       <= '0;
      eng_key_load  <= 1'b0;
      eng_data_load <= 1'b0;
      eng_post_rdy  <= 1'b0;
    end else begin
      eng_key_load  <= 1'b0;
      eng_data_load <= 1'b0;
      eng_post_rdy  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.req_valid) begin
            alg_q         <= bus.req_alg;
            decrypt_q     <= bus.req_decrypt;
            eng_input     <= bus.req_data;
            eng_key       <= bus.req_key;
            bus.req_ready <= 1'b0;
            if (bus.req_alg == ALG_ILLEGAL) begin
              state         <= ST_RESP;
              bus.rsp_valid <= 1'b1;
              bus.rsp_err   <= 1'b1;
              bus.rsp_data  <= '0;
            end else begin
              state        <= ST_LOAD_KEY;
              eng_key_load <= 1'b1;
            end
          end
        end
        ST_LOAD_KEY: begin
          state         <= ST_LOAD_DATA;
          eng_data_load <= 1'b1;
        end
        ST_LOAD_DATA: state <= ST_RUN;
        ST_RUN: begin
          if (alg_q == ALG_HIGHT) begin
            if (eng_ready_o) begin
              state <= ST_CAPTURE;
            end else if (cnt_done) begin
              state         <= ST_RESP;
              bus.rsp_valid <= 1'b1;
              bus.rsp_err   <= 1'b1;
              bus.rsp_data  <= '0;
            end
          end else if (cnt_done) begin
            state <= ST_DRAIN;
          end
        end
        ST_DRAIN: if (cnt_done) state <= ST_CAPTURE;
        ST_CAPTURE: begin
          state         <= ST_RESP;
          bus.rsp_valid <= 1'b1;
          bus.rsp_err   <= 1'b0;
          bus.rsp_data  <= eng_output;
        end
        ST_RESP: begin
          if (bus.rsp_ready) begin
            state         <= ST_IDLE;
            bus.rsp_valid <= 1'b0;
            bus.req_ready <= 1'b1;
            eng_post_rdy  <= (alg_q == ALG_HIGHT);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_crypto_job_sequencer.sv
// tb/tb_crypto_job_sequencer.sv - directed self-checking bench for crypto_job_sequencer
module tb_crypto_job_sequencer;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [63:0]  eng_input;
  logic [167:0] eng_key;
  logic [1:0]   eng_sel;
  logic [5:0]   eng_roundSel;
  logic         eng_decrypt, eng_op, eng_key_load, eng_data_load, eng_post_rdy;
  logic [63:0]  eng_output = 64'd0;
  logic         eng_ready_o = 1'b0;

  int passed = 0;
  int total  = 0;

  localparam logic [167:0] KEY1 = {40'h0, 64'h1133_5577_99BB_DDFF, 64'h0F1E_2D3C_4B5A_6978};
  localparam logic [167:0] KEY2 = {104'h0, 64'hFEDC_BA98_7654_3210};
  localparam logic [63:0]  OUT_D = 64'hA5A5_5A5A_0F0F_F000;
  localparam logic [63:0]  OUT_P = 64'h1234_5678_9ABC_DE00;
  localparam logic [63:0]  OUT_H = 64'hCAFE_F00D_BEEF_0000;

  crypto_job_sequencer_if bus();

  crypto_job_sequencer #(
    .DES_ROUNDS(16), .PRESENT_CYCLES(32), .PIPE_LAT(2), .HIGHT_TIMEOUT(64)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .eng_input(eng_input), .eng_key(eng_key), .eng_sel(eng_sel),
    .eng_roundSel(eng_roundSel), .eng_decrypt(eng_decrypt), .eng_op(eng_op),
    .eng_key_load(eng_key_load), .eng_data_load(eng_data_load),
    .eng_post_rdy(eng_post_rdy), .eng_output(eng_output), .eng_ready_o(eng_ready_o)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout sim time exceeded, required finish");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input logic [1:0] alg, input logic dec,
                           input logic [167:0] key, input logic [63:0] data);
    bus.req_valid   = 1'b1;
    bus.req_alg     = alg;
    bus.req_decrypt = dec;
    bus.req_key     = key;
    bus.req_data    = data;
    tick();
    bus.req_valid = 1'b0;
  endtask

  // Observes cycle t (t=1 is the cycle after the accept edge) until rsp_valid.
  // eng_output = base ^ t so the captured value pins down the capture cycle.
  task automatic monitor(input int rdy_t, input logic [1:0] alg, input logic [63:0] base,
                         output int lat, output int kl, output int kl_t,
                         output int dl, output int dl_t, output int rerr, output int rr_bad);
    int t;
    int exp_rs;
    lat = -1; kl = 0; kl_t = -1; dl = 0; dl_t = -1; rerr = 0; rr_bad = 0;
    t = 1;
    while (t <= 200) begin
      eng_ready_o = (t == rdy_t);
      eng_output  = base ^ 64'(t);
      if (eng_key_load)  begin kl++; kl_t = t; end
      if (eng_data_load) begin dl++; dl_t = t; end
      exp_rs = (alg == 2'd0 && t >= 3 && t <= 18) ? t - 3 : 0;
      if (int'(eng_roundSel) != exp_rs) rerr++;
      if (bus.req_ready) rr_bad++;
      if (bus.rsp_valid) begin lat = t; break; end
      tick();
      t++;
    end
    eng_ready_o = 1'b0;
  endtask

  task automatic handshake;
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (bus.req_ready !== 1'b1) $display("FAIL reset_req_ready got %b want 1", bus.req_ready);
    else passed++;
    total++;
    if ({bus.rsp_valid, bus.rsp_err, bus.rsp_data, bus.rsp_alg, eng_input, eng_key, eng_sel,
         eng_roundSel, eng_decrypt, eng_op, eng_key_load, eng_data_load, eng_post_rdy} !== '0)
      $display("FAIL reset_zero_outputs got nonzero want all zero");
    else passed++;
    reset = 1'b0;
    tick();
    total++;
    if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0)
      $display("FAIL reset_release got rdy=%b vld=%b want 1/0", bus.req_ready, bus.rsp_valid);
    else passed++;
  endtask

  task automatic test_des3;
    int lat, kl, kl_t, dl, dl_t, rerr, rr_bad;
    start_job(2'd0, 1'b0, KEY1, 64'h0123_4567_89AB_CDEF);
    monitor(-1, 2'd0, OUT_D, lat, kl, kl_t, dl, dl_t, rerr, rr_bad);
    total++;
    if (lat !== 22) $display("FAIL des_latency got %0d want 22", lat); else passed++;
    total++;
    if (kl !== 1 || kl_t !== 1 || dl !== 1 || dl_t !== 2)
      $display("FAIL des_load_strobes got kl=%0d@%0d dl=%0d@%0d want 1@1 1@2", kl, kl_t, dl, dl_t);
    else passed++;
    total++;
    if (rerr !== 0) $display("FAIL des_roundsel got %0d bad cycles want 0", rerr); else passed++;
    total++;
    if (rr_bad !== 0) $display("FAIL des_req_ready got %0d ready cycles want 0", rr_bad); else passed++;
    total++;
    if (bus.rsp_data !== (OUT_D ^ 64'd21) || bus.rsp_err !== 1'b0 || bus.rsp_alg !== 2'd0)
      $display("FAIL des_rsp got %h err=%b alg=%0d want %h 0 0", bus.rsp_data, bus.rsp_err,
               bus.rsp_alg, OUT_D ^ 64'd21);
    else passed++;
    total++;
    if (eng_input !== 64'h0123_4567_89AB_CDEF || eng_key !== KEY1 || eng_sel !== 2'd0)
      $display("FAIL des_eng_held got in=%h sel=%0d want 0123456789abcdef 0", eng_input, eng_sel);
    else passed++;
    handshake();
    total++;
    if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1 || eng_post_rdy !== 1'b0)
      $display("FAIL des_handshake got vld=%b rdy=%b post=%b want 0 1 0", bus.rsp_valid,
               bus.req_ready, eng_post_rdy);
    else passed++;
  endtask

  task automatic test_present_stall_back_to_back;
    int lat, kl, kl_t, dl, dl_t, rerr, rr_bad;
    int bad;
    logic [63:0] held;
    start_job(2'd1, 1'b1, KEY2, 64'h0011_2233_4455_6677);
    monitor(-1, 2'd1, OUT_P, lat, kl, kl_t, dl, dl_t, rerr, rr_bad);
    total++;
    if (lat !== 38) $display("FAIL present_latency got %0d want 38", lat); else passed++;
    total++;
    if (rerr !== 0 || dl_t !== 2) $display("FAIL present_roundsel_load got rerr=%0d dl_t=%0d want 0 2", rerr, dl_t);
    else passed++;
    total++;
    if (bus.rsp_data !== (OUT_P ^ 64'd37) || bus.rsp_alg !== 2'd1 || eng_sel !== 2'd1)
      $display("FAIL present_rsp got %h alg=%0d want %h 1", bus.rsp_data, bus.rsp_alg, OUT_P ^ 64'd37);
    else passed++;
    total++;
    if (eng_decrypt !== 1'b1 || eng_op !== 1'b1)
      $display("FAIL present_decrypt got dec=%b op=%b want 1 1", eng_decrypt, eng_op);
    else passed++;
    // Offer a new (illegal, encrypt) job during the stall: it must not be taken.
    held = OUT_P ^ 64'd37;
    bad = 0;
    bus.req_valid = 1'b1; bus.req_alg = 2'd3; bus.req_decrypt = 1'b0; bus.req_data = 64'hFFFF;
    for (int i = 0; i < 10; i++) begin
      eng_output = 64'h5555_0000_0000_0000 + 64'(i);
      tick();
      if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== held || bus.req_ready !== 1'b0 ||
          eng_decrypt !== 1'b1 || eng_key_load !== 1'b0) bad++;
    end
    total++;
    if (bad !== 0) $display("FAIL present_stall got %0d bad cycles want 0", bad); else passed++;
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    total++;
    if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1)
      $display("FAIL b2b_idle got vld=%b rdy=%b want 0 1", bus.rsp_valid, bus.req_ready);
    else passed++;
    tick();
    bus.req_valid = 1'b0;
    total++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_err !== 1'b1 || bus.rsp_data !== 64'd0 || bus.rsp_alg !== 2'd3)
      $display("FAIL b2b_accept got vld=%b err=%b data=%h alg=%0d want 1 1 0 3", bus.rsp_valid,
               bus.rsp_err, bus.rsp_data, bus.rsp_alg);
    else passed++;
    handshake();
  endtask

  task automatic test_hight;
    int lat, kl, kl_t, dl, dl_t, rerr, rr_bad;
    start_job(2'd2, 1'b0, KEY2, 64'h8899_AABB_CCDD_EEFF);
    monitor(9, 2'd2, OUT_H, lat, kl, kl_t, dl, dl_t, rerr, rr_bad);
    total++;
    if (lat !== 11) $display("FAIL hight_latency got %0d want 11", lat); else passed++;
    total++;
    if (bus.rsp_err !== 1'b0 || bus.rsp_data !== (OUT_H ^ 64'd10))
      $display("FAIL hight_rsp got %h err=%b want %h 0", bus.rsp_data, bus.rsp_err, OUT_H ^ 64'd10);
    else passed++;
    handshake();
    total++;
    if (eng_post_rdy !== 1'b1) $display("FAIL hight_post_rdy got %b want 1", eng_post_rdy); else passed++;
    tick();
    total++;
    if (eng_post_rdy !== 1'b0) $display("FAIL hight_post_rdy_pulse got %b want 0", eng_post_rdy); else passed++;
  endtask

  task automatic test_hight_timeout;
    int lat, kl, kl_t, dl, dl_t, rerr, rr_bad;
    start_job(2'd2, 1'b0, KEY1, 64'h1);
    monitor(-1, 2'd2, OUT_H, lat, kl, kl_t, dl, dl_t, rerr, rr_bad);
    total++;
    if (lat !== 67) $display("FAIL hight_timeout_latency got %0d want 67", lat); else passed++;
    total++;
    if (bus.rsp_err !== 1'b1 || bus.rsp_data !== 64'd0)
      $display("FAIL hight_timeout_rsp got %h err=%b want 0 1", bus.rsp_data, bus.rsp_err);
    else passed++;
    handshake();
  endtask

  task automatic test_illegal;
    int lat, kl, kl_t, dl, dl_t, rerr, rr_bad;
    start_job(2'd3, 1'b0, KEY1, 64'h2);
    monitor(-1, 2'd3, OUT_D, lat, kl, kl_t, dl, dl_t, rerr, rr_bad);
    total++;
    if (lat !== 1) $display("FAIL illegal_latency got %0d want 1", lat); else passed++;
    total++;
    if (kl !== 0 || dl !== 0) $display("FAIL illegal_strobes got kl=%0d dl=%0d want 0 0", kl, dl); else passed++;
    total++;
    if (bus.rsp_err !== 1'b1 || bus.rsp_data !== 64'd0)
      $display("FAIL illegal_rsp got %h err=%b want 0 1", bus.rsp_data, bus.rsp_err);
    else passed++;
    handshake();
  endtask

  task automatic test_reset_mid_job;
    int bad;
    start_job(2'd0, 1'b1, KEY1, 64'h0123_4567_89AB_CDEF);
    repeat (9) tick();
    total++;
    if (eng_roundSel !== 6'd7) $display("FAIL midrst_pre_round got %0d want 7", eng_roundSel); else passed++;
    #2 reset = 1'b1;
    #1;
    total++;
    if (bus.req_ready !== 1'b1 ||
        {bus.rsp_valid, bus.rsp_err, bus.rsp_data, bus.rsp_alg, eng_input, eng_key, eng_sel,
         eng_roundSel, eng_decrypt, eng_op, eng_key_load, eng_data_load, eng_post_rdy} !== '0)
      $display("FAIL midrst_async got rdy=%b or nonzero outputs want 1 and zeros", bus.req_ready);
    else passed++;
    #2 reset = 1'b0;
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1 || eng_roundSel !== 6'd0) bad++;
    end
    total++;
    if (bad !== 0) $display("FAIL midrst_no_stale got %0d bad cycles want 0", bad); else passed++;
  endtask

  initial begin
    bus.req_valid = 1'b0; bus.req_alg = 2'd0; bus.req_decrypt = 1'b0;
    bus.req_key = '0; bus.req_data = '0; bus.rsp_ready = 1'b0;
    test_reset();
    test_des3();
    test_present_stall_back_to_back();
    test_hight();
    test_hight_timeout();
    test_illegal();
    test_reset_mid_job();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
